hazard_unit: RTL
================

// Module: hazard_unit
// PURPOSE
//  Sequences the 5-stage pipelined datapath. Drives stall, flush and forwarding-select controls.
//  Resolves RAW hazards by forwarding, load-use hazards by a 1-cycle interlock, taken
//  branches/jumps by flushing D/E, and variable-latency data memory by freezing the pipeline.
//  Holds a memory-wait FSM with a timeout fault, plus saturating stall/flush performance counters.
// PARAMETERS
//  MEM_TIMEOUT  16  max consecutive memory-wait cycles before the sticky fault is raised
//  CNT_W        32  width of each performance counter
// PORTS
//  clk          in   1      pipeline clock; all state updates on rising edge
//  reset        in   1      asynchronous, active-low reset
//  Rs1D,Rs2D    in   5      source registers of the instruction in Decode
//  Rs1E,Rs2E    in   5      source registers of the instruction in Execute
//  RdE,RdM,RdW  in   5      destination registers in Execute/Memory/Writeback
//  ResultSrcE0  in   1      1 = instruction in Execute is a load
//  RegWriteM    in   1      Memory-stage instruction writes the register file
//  RegWriteW    in   1      Writeback-stage instruction writes the register file
//  PCSrcE       in   1      branch/jump taken, resolved in Execute
//  MemReqM      in   1      load/store active in Memory stage
//  MemReadyM    in   1      data memory completes the Memory-stage access this cycle
//  perf_clr     in   1      synchronous clear of both counters
//  StallF,StallD,StallE,StallM  out 1  hold PC / IF-ID / ID-EX / EX-MEM registers
//  FlushD,FlushE,FlushW         out 1  bubble IF-ID / ID-EX / MEM-WB registers
//  ForwardAE,ForwardBE          out 2  SrcA / WriteData forward select
//  mem_fault    out  1      sticky: memory timeout occurred
//  stall_cnt    out  CNT_W  cycles with StallF=1
//  flush_cnt    out  CNT_W  cycles with taken-branch flush
// BEHAVIOUR
//  Reset (reset=0, async)
//   - FSM goes to MW_IDLE; wait_cnt=0, mem_fault=0, both counters=0.
//   - Combinational outputs while reset=0: all Stall*=0, Flush*=1, Forward*=FWD_RF.
//  Forwarding (combinational, per source s in {Rs1E->A, Rs2E->B})
//   - FWD_MEM(10) if s!=0 && s==RdM && RegWriteM.
//   - else FWD_WB(01) if s!=0 && s==RdW && RegWriteW.
//   - else FWD_RF(00).
//   - M has priority over W. x0 is never forwarded.
//  Memory stall
//   - mem_stall = MemReqM & ~MemReadyM, or state==MW_FAULT.
//   - When mem_stall: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0.
//   - Load-use and branch actions are suppressed (E is frozen); they re-evaluate after release.
//  Load-use (only when ~mem_stall)
//   - lw = ResultSrcE0 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D) && ~PCSrcE.
//   - lw gives StallF=StallD=1 and FlushE=1 for exactly 1 cycle.
//  Branch (only when ~mem_stall)
//   - PCSrcE gives FlushD=1 and FlushE=1. StallF=0, so the PC redirect is taken.
//  Default: every Stall*/Flush* is 0.
//  FSM (mw_state_e)
//   - MW_IDLE: mem_stall term true -> MW_WAIT with wait_cnt=1.
//   - MW_WAIT: MemReadyM -> MW_IDLE, wait_cnt=0. Otherwise wait_cnt++.
//     When wait_cnt==MEM_TIMEOUT with no ready -> MW_FAULT.
//   - MW_FAULT: terminal until reset. mem_fault=1, pipeline frozen.
//   - A single-cycle access (MemReadyM with MemReqM) never leaves MW_IDLE.
//   - MemReqM dropping in MW_WAIT is a protocol error: return to MW_IDLE.
//  Counters
//   - stall_cnt increments when StallF=1. flush_cnt increments when PCSrcE & ~mem_stall.
//   - Both saturate at all-ones; neither wraps.
//   - perf_clr beats a same-cycle increment (result 0). perf_clr does not clear mem_fault.
// STRUCTURE
//  Shared package types_pkg gains:
//   - fwd_sel_e {FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10}
//   - mw_state_e {MW_IDLE, MW_WAIT, MW_FAULT}
//  Sub-module sat_counter #(W): inc, clr, q. Instantiated twice (stall_cnt, flush_cnt).
// TESTING
//  1. RdM=5,RegWriteM=1 and RdW=5,RegWriteW=1, Rs1E=5
//     -> ForwardAE=10. Then Rs1E=0 with RdM=0 -> ForwardAE=00.
//  2. ResultSrcE0=1,RdE=7,Rs2D=7 -> one cycle of StallF=StallD=FlushE=1.
//     Next cycle (load moved to M) -> all 0 and ForwardBE=10.
//  3. PCSrcE=1 with lw condition also true -> FlushD=FlushE=1, StallF=0, flush_cnt+1.
//  4. MemReqM=1, MemReadyM low 3 cycles then high
//     -> Stall{F,D,E,M}=FlushW=1 for 3 cycles, FSM IDLE->WAIT->IDLE, stall_cnt+=3.
//  5. MemReadyM held low with MEM_TIMEOUT=4 -> mem_fault=1 after 4 wait cycles.
//     Outputs stay frozen; perf_clr clears counters but not the fault.
//  6. reset low mid-MW_WAIT -> immediately MW_IDLE, counters=0, Flush*=1.
//     Saturation check with CNT_W=4: 20 stall cycles -> stall_cnt=15.

Source files
------------

// File: rtl/types_pkg.sv
// Shared types for the pipeline hazard unit: forwarding selects, memory-wait
// FSM states, and the forwarding-priority helper.
package types_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MW_IDLE  = 2'd0,
        MW_WAIT  = 2'd1,
        MW_FAULT = 2'd2
    } mw_state_e;

    // Memory stage wins over writeback; x0 is hardwired zero and never forwarded.
    function automatic fwd_sel_e fwd_sel(input logic [4:0] src,
                                         input logic [4:0] rd_m,
                                         input logic [4:0] rd_w,
                                         input logic       wr_m,
                                         input logic       wr_w);
        fwd_sel_e sel;
        sel = FWD_RF;
        if (src != 5'd0 && src == rd_m && wr_m) begin
            sel = FWD_MEM;
        end else if (src != 5'd0 && src == rd_w && wr_w) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && cnt_q != '1) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// Hazard unit for the 5-stage pipeline: forwarding, load-use interlock, branch
// flush, memory-wait freeze with timeout fault, and stall/flush counters.
//
// state    | meaning
// MW_IDLE  | no outstanding multi-cycle memory access
// MW_WAIT  | Memory-stage access pending, wait_cnt counts cycles waited
// MW_FAULT | timeout hit; pipeline frozen until reset
module hazard_unit
    import types_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             ResultSrcE0,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    input  logic             perf_clr,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    mw_state_e      state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           mem_stall;
    logic           lw_stall;
    logic           flush_inc;

    assign mem_stall = (MemReqM && !MemReadyM) || (state_q == MW_FAULT);
    assign lw_stall  = ResultSrcE0 && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D) && !PCSrcE;
    assign mem_fault = (state_q == MW_FAULT);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            MW_IDLE: begin
                if (MemReqM && !MemReadyM) begin
                    state_d    = MW_WAIT;
                    wait_cnt_d = WCW'(1);
                end
            end
            MW_WAIT: begin
                // A dropped request is a protocol error; recover rather than fault.
                if (MemReadyM || !MemReqM) begin
                    state_d    = MW_IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WCW'(MEM_TIMEOUT)) begin
                    state_d = MW_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            MW_FAULT: begin
                state_d = MW_FAULT;
            end
            default: begin
                state_d    = MW_IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= MW_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        flush_inc = 1'b0;
        if (!reset) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else begin
            ForwardAE = fwd_sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
            ForwardBE = fwd_sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);
            // Memory freeze holds E too, so load-use and branch wait until release.
            if (mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (lw_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end else if (PCSrcE) begin
                FlushD    = 1'b1;
                FlushE    = 1'b1;
                flush_inc = 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (StallF),
        .clr   (perf_clr),
        .q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (flush_inc),
        .clr   (perf_clr),
        .q     (flush_cnt)
    );

endmodule
